// File: rtl/rns_lift_param.sv
// rtl/rns_lift_param.sv - streaming RNS basis-extension (fast base conversion) unit
// Lifts one coefficient from NQ source residues to NP target residues via a shared bit-serial reducer.
module rns_lift_param #(
    parameter int W   = 30,
    parameter int NQ  = 6,
    parameter int NP  = 7,
    parameter int AW  = 3,
    parameter int KAW = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic [AW-1:0]  rd_addr_q,
    input  logic [W-1:0]   coeff_in_q,
    output logic [KAW-1:0] k_addr,
    input  logic [W-1:0]   k_data,
    output logic [W-1:0]   result,
    output logic [AW-1:0]  result_addr,
    output logic           result_we
);
    localparam int LG     = $clog2(NQ);
    localparam int ACW    = 2*W + LG;
    localparam int S1_LEN = 2*W + 3;
    localparam int S2_LEN = NQ + 2*W + LG + 3;
    localparam int CW     = $clog2(S2_LEN + 1);

    localparam logic [CW-1:0] S1_LAST     = CW'(S1_LEN - 1);
    localparam logic [CW-1:0] S2_ACC_END  = CW'(NQ + 1);
    localparam logic [CW-1:0] S2_RED_LAST = CW'(S2_LEN - 2);
    localparam logic [CW-1:0] S2_LAST     = CW'(S2_LEN - 1);
    localparam logic [AW-1:0] IQ_LAST     = AW'(NQ - 1);
    localparam logic [AW-1:0] JP_LAST     = AW'(NP - 1);

    typedef enum logic [1:0] {IDLE, S1, S2, DONE} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cyc, cyc_nx;
    logic [AW-1:0]   idx, idx_nx;
    logic [AW-1:0]   rd_hold;
    logic [KAW-1:0]  k_hold;
    logic [ACW-1:0]  acc;
    logic [W:0]      r;
    logic [W-1:0]    m;
    logic [W-1:0]    y [NQ];

    logic            ld_prod, ld_m, clr_acc, add_acc, reduce, store_y, wr;

    // One multiplier serves both x_i*qhatinv_i and y_i*qhat_i.
    logic [AW-1:0]   yi;
    logic [W-1:0]    mul_a;
    logic [2*W-1:0]  prod;

    assign yi    = AW'(cyc - CW'(2));
    assign mul_a = (state == S1) ? coeff_in_q : y[yi];
    assign prod  = {{W{1'b0}}, mul_a} * {{W{1'b0}}, k_data};

    // Restoring reduction step; r < m keeps 2r+bit within W+1 bits.
    logic [W:0]      red_t, red_n;
    assign red_t = (r << 1) | {{W{1'b0}}, acc[ACW-1]};
    assign red_n = (red_t >= {1'b0, m}) ? red_t - {1'b0, m} : red_t;

    assign busy = (state != IDLE);

    always_comb begin
        state_nx  = state;
        cyc_nx    = cyc + 1'b1;
        idx_nx    = idx;
        rd_addr_q = rd_hold;
        k_addr    = k_hold;
        ld_prod   = 1'b0;
        ld_m      = 1'b0;
        clr_acc   = 1'b0;
        add_acc   = 1'b0;
        reduce    = 1'b0;
        store_y   = 1'b0;
        wr        = 1'b0;
        case (state)
            IDLE, DONE: begin
                cyc_nx = '0;
                if (start) begin
                    state_nx = S1;
                    idx_nx   = '0;
                end else begin
                    state_nx = IDLE;
                end
            end
            S1: begin
                if (cyc == '0) begin
                    rd_addr_q = idx;
                    k_addr    = KAW'(NQ) + KAW'(idx);
                end else if (cyc == CW'(1)) begin
                    ld_prod = 1'b1;
                    k_addr  = KAW'(idx);
                end else if (cyc == CW'(2)) begin
                    ld_m = 1'b1;
                end else begin
                    reduce = 1'b1;
                end
                if (cyc == S1_LAST) begin
                    store_y = 1'b1;
                    cyc_nx  = '0;
                    if (idx == IQ_LAST) begin
                        state_nx = S2;
                        idx_nx   = '0;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end
            end
            S2: begin
                if (cyc == '0) begin
                    k_addr  = KAW'(2*NQ) + KAW'(idx);
                    clr_acc = 1'b1;
                end else if (cyc <= CW'(NQ)) begin
                    k_addr = KAW'(2*NQ + NP) + KAW'(idx) * KAW'(NQ) + KAW'(cyc - 1'b1);
                end
                if (cyc == CW'(1)) begin
                    ld_m = 1'b1;
                end
                // ROM data trails the issued address by one cycle.
                if (cyc >= CW'(2) && cyc <= S2_ACC_END) begin
                    add_acc = 1'b1;
                end
                if (cyc > S2_ACC_END && cyc <= S2_RED_LAST) begin
                    reduce = 1'b1;
                end
                if (cyc == S2_LAST) begin
                    wr     = 1'b1;
                    cyc_nx = '0;
                    if (idx == JP_LAST) begin
                        state_nx = DONE;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cyc         <= '0;
            idx         <= '0;
            rd_hold     <= '0;
            k_hold      <= '0;
            acc         <= '0;
            r           <= '0;
            m           <= '0;
            done        <= 1'b0;
            result      <= '0;
            result_addr <= '0;
            result_we   <= 1'b0;
        end else begin
            state   <= state_nx;
            cyc     <= cyc_nx;
            idx     <= idx_nx;
            rd_hold <= rd_addr_q;
            k_hold  <= k_addr;
            done    <= (state == DONE);
            if (ld_prod) begin
                acc <= {prod, {LG{1'b0}}};
            end else if (clr_acc) begin
                acc <= '0;
            end else if (add_acc) begin
                acc <= acc + {{LG{1'b0}}, prod};
            end else if (reduce) begin
                acc <= {acc[ACW-2:0], 1'b0};
            end
            if (ld_m) begin
                m <= k_data;
                r <= '0;
            end else if (reduce) begin
                r <= red_n;
            end
            result_we <= wr;
            if (wr) begin
                result      <= r[W-1:0];
                result_addr <= idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (store_y) begin
            y[idx] <= red_n[W-1:0];
        end
    end

endmodule

// File: tb/tb_rns_lift_param.sv
// tb/tb_rns_lift_param.sv - scoreboard bench for rns_lift_param
// Random residues against a modular-arithmetic reference model; a monitor pops expected writes.
module tb_rns_lift_param;
    localparam int LAT  = 883;
    localparam int LAT6 = 185;

    typedef struct {
        int              addr;
        longint unsigned val;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst, start, busy, done, result_we;
    logic [2:0]  rd_addr_q, result_addr;
    logic [5:0]  k_addr;
    logic [29:0] coeff_in_q, k_data, result;

    logic        start6, busy6, done6, we6;
    logic [1:0]  rd6, raddr6;
    logic [3:0]  kaddr6;
    logic [15:0] coeff6, kdata6, result6;

    rns_lift_param dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd_addr_q(rd_addr_q), .coeff_in_q(coeff_in_q), .k_addr(k_addr), .k_data(k_data),
        .result(result), .result_addr(result_addr), .result_we(result_we)
    );

    rns_lift_param #(.W(16), .NQ(2), .NP(3), .AW(2), .KAW(4)) dut6 (
        .clk(clk), .rst(rst), .start(start6), .busy(busy6), .done(done6),
        .rd_addr_q(rd6), .coeff_in_q(coeff6), .k_addr(kaddr6), .k_data(kdata6),
        .result(result6), .result_addr(raddr6), .result_we(we6)
    );

    longint unsigned rom [64];
    longint unsigned x   [8];
    longint unsigned rom6[64];
    longint unsigned x6  [8];
    longint unsigned qm  [8];
    longint unsigned pm  [8];

    always @(posedge clk) begin
        k_data     <= rom[k_addr][29:0];
        coeff_in_q <= x[rd_addr_q][29:0];
        kdata6     <= rom6[kaddr6][15:0];
        coeff6     <= x6[rd6][15:0];
    end

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic longint unsigned inv_mod(input longint unsigned a, input longint unsigned m);
        longint t = 0, nt = 1, r = longint'(m), nr = longint'(a % m), qq, tmp;
        while (nr != 0) begin
            qq = r / nr;
            tmp = t - qq * nt; t = nt; nt = tmp;
            tmp = r - qq * nr; r = nr; nr = tmp;
        end
        if (t < 0) t += longint'(m);
        return longint'(t);
    endfunction

    function automatic void build_rom(input int nq, input int np, input longint unsigned q[8],
                                      input longint unsigned p[8], output longint unsigned rm[64]);
        longint unsigned h;
        for (int a = 0; a < 64; a++) rm[a] = 0;
        for (int i = 0; i < nq; i++) begin
            rm[i] = q[i];
            h = 1;
            for (int k = 0; k < nq; k++) if (k != i) h = (h * (q[k] % q[i])) % q[i];
            rm[nq + i] = inv_mod(h, q[i]);
        end
        for (int j = 0; j < np; j++) begin
            rm[2*nq + j] = p[j];
            for (int i = 0; i < nq; i++) begin
                h = 1;
                for (int k = 0; k < nq; k++) if (k != i) h = (h * (q[k] % p[j])) % p[j];
                rm[2*nq + np + j*nq + i] = h;
            end
        end
    endfunction

    function automatic void model(input int nq, input int np, input longint unsigned rm[64],
                                  input longint unsigned xv[8], output longint unsigned res[8]);
        longint unsigned yv, s, pj;
        for (int j = 0; j < 8; j++) res[j] = 0;
        for (int j = 0; j < np; j++) begin
            pj = rm[2*nq + j];
            s = 0;
            for (int i = 0; i < nq; i++) begin
                yv = (xv[i] * rm[nq + i]) % rm[i];
                s  = (s + (yv * rm[2*nq + np + j*nq + i]) % pj) % pj;
            end
            res[j] = s;
        end
    endfunction

    wr_t exp_q[$];
    int  done_q[$];
    wr_t exp6_q[$];
    int  done6_q[$];
    wr_t mon_e, mon6_e;

    task automatic push_main(input int acc_cyc);
        longint unsigned res[8];
        model(6, 7, rom, x, res);
        for (int j = 0; j < 7; j++) exp_q.push_back('{j, res[j]});
        done_q.push_back(acc_cyc + LAT);
    endtask

    task automatic issue_main(input bit keep);
        start = 1'b1;
        @(posedge clk);
        #1;
        push_main(cyc);
        if (!keep) start = 1'b0;
    endtask

    task automatic wait_done(input int lim, input string nm);
        int n = 0;
        @(negedge clk);
        while (!done && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(nm, done, 1);
    endtask

    task automatic rand_x();
        for (int i = 0; i < 8; i++) x[i] = longint'($urandom() & 32'h3FFF_FFFF);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (result_we) begin
                chk("write_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("write_addr", result_addr, mon_e.addr);
                    chk("write_data", result, mon_e.val);
                end
            end
            if (done) begin
                chk("done_pending", done_q.size() > 0, 1);
                if (done_q.size() > 0) chk("done_cycle", cyc, done_q.pop_front());
            end else if (done_q.size() > 0 && cyc > done_q[0]) begin
                chk("done_late", done, 1);
                void'(done_q.pop_front());
            end
            if (we6) begin
                chk("t6_write_pending", exp6_q.size() > 0, 1);
                if (exp6_q.size() > 0) begin
                    mon6_e = exp6_q.pop_front();
                    chk("t6_write_addr", raddr6, mon6_e.addr);
                    chk("t6_write_data", result6, mon6_e.val);
                end
            end
            if (done6) begin
                chk("t6_done_pending", done6_q.size() > 0, 1);
                if (done6_q.size() > 0) chk("t6_done_cycle", cyc, done6_q.pop_front());
            end else if (done6_q.size() > 0 && cyc > done6_q[0]) begin
                chk("t6_done_late", done6, 1);
                void'(done6_q.pop_front());
            end
        end
    end

    bit t4_on = 1'b0;
    int t4_busy_low = 0;
    always @(negedge clk) if (t4_on && !busy && !done) t4_busy_low++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        longint unsigned res6[8];
        int n;
        rst = 1'b1; start = 1'b0; start6 = 1'b0;
        qm = '{1073741789, 1073741783, 1073741741, 1073741723, 1073741719, 1073741717, 0, 0};
        pm = '{1073741689, 1073741671, 1073741663, 1073741651, 1073741621, 1073741591, 1073741567, 0};
        build_rom(6, 7, qm, pm, rom);
        for (int i = 0; i < 8; i++) begin x[i] = 0; x6[i] = 0; end
        for (int a = 0; a < 64; a++) rom6[a] = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we", result_we, 0);
        chk("rst_result", result, 0);
        chk("rst_result_addr", result_addr, 0);
        chk("rst_rd_addr_q", rd_addr_q, 0);
        chk("rst_k_addr", k_addr, 0);
        rst = 1'b0;
        @(negedge clk);

        rand_x();
        issue_main(1'b0);
        wait_done(LAT + 10, "t1_done_seen");
        chk("t1_all_writes", exp_q.size(), 0);

        for (int i = 0; i < 8; i++) x[i] = 0;
        issue_main(1'b0);
        wait_done(LAT + 10, "t2_done_seen");
        chk("t2_all_writes", exp_q.size(), 0);

        for (int i = 0; i < 6; i++) rom[6 + i] = rom[i] - 1;
        for (int j = 0; j < 7; j++)
            for (int i = 0; i < 6; i++) rom[19 + j*6 + i] = rom[12 + j] - 1;
        for (int i = 0; i < 8; i++) x[i] = 64'h3FFF_FFFF;
        issue_main(1'b0);
        wait_done(LAT + 10, "t3_done_seen");
        chk("t3_all_writes", exp_q.size(), 0);
        build_rom(6, 7, qm, pm, rom);

        rand_x();
        issue_main(1'b1);
        t4_on = 1'b1;
        for (int s = 1; s < 3; s++) begin
            wait_done(LAT + 10, "t4_done_seen");
            chk("t4_busy_at_done", busy, 1);
            // the following set was accepted on the edge that raised done
            rand_x();
            push_main(cyc);
            if (s == 2) start = 1'b0;
        end
        wait_done(LAT + 10, "t4_done_seen");
        t4_on = 1'b0;
        chk("t4_busy_held", t4_busy_low, 0);
        chk("t4_all_writes", exp_q.size(), 0);

        rand_x();
        issue_main(1'b0);
        repeat (400) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        done_q.delete();
        @(negedge clk);
        chk("t5_busy", busy, 0);
        chk("t5_we", result_we, 0);
        chk("t5_k_addr", k_addr, 0);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        chk("t5_idle_busy", busy, 0);
        rand_x();
        issue_main(1'b0);
        wait_done(LAT + 10, "t5_done_seen");
        chk("t5_all_writes", exp_q.size(), 0);

        qm = '{65521, 65519, 0, 0, 0, 0, 0, 0};
        pm = '{65497, 65479, 65449, 0, 0, 0, 0, 0};
        build_rom(2, 3, qm, pm, rom6);
        x6[0] = 65520; x6[1] = 65518;
        @(negedge clk);
        start6 = 1'b1;
        @(posedge clk);
        #1;
        model(2, 3, rom6, x6, res6);
        for (int j = 0; j < 3; j++) exp6_q.push_back('{j, res6[j]});
        done6_q.push_back(cyc + LAT6);
        start6 = 1'b0;
        n = 0;
        @(negedge clk);
        while (!done6 && n < LAT6 + 10) begin
            @(negedge clk);
            n++;
        end
        chk("t6_done_seen", done6, 1);
        chk("t6_all_writes", exp6_q.size(), 0);

        repeat (5) @(negedge clk);
        chk("end_no_pending_done", done_q.size() + done6_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
